// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pattern controller: pattern mode encodings,
// default 640x480@60 timing and a constant width helper.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_GRAD  = 2'd3
  } mode_t;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Bits needed to hold 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical raster counters with sync and active-region decode.
// Counters sit at 0,0 while enable is low and start counting from there.
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic SYNC_POL = 1'b0,
  parameter int   XW       = clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int   YW       = clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic [XW-1:0] h_cnt,
  output logic [YW-1:0] v_cnt,
  output logic          h_sync,
  output logic          v_sync,
  output logic          active,
  output logic          at_origin,
  output logic          line_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT_C  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT_C  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

  assign line_end  = (h_cnt == H_LAST);
  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  assign active    = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
  assign h_sync    = ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? SYNC_POL : ~SYNC_POL;
  assign v_sync    = ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? SYNC_POL : ~SYNC_POL;

  // Raster position: h wraps every line, v advances on each h wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!enable) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (line_end) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + YW'(1);
    end else begin
      h_cnt <= h_cnt + XW'(1);
    end
  end

endmodule

// File: rtl/vga_pattern_controller.sv
// VGA timing generator with four runtime-selectable test patterns. All
// outputs are registered one clock after the raster counters.
module vga_pattern_controller
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE   = VGA_H_ACTIVE,
  parameter int   H_FP       = VGA_H_FP,
  parameter int   H_SYNC     = VGA_H_SYNC,
  parameter int   H_BP       = VGA_H_BP,
  parameter int   V_ACTIVE   = VGA_V_ACTIVE,
  parameter int   V_FP       = VGA_V_FP,
  parameter int   V_SYNC     = VGA_V_SYNC,
  parameter int   V_BP       = VGA_V_BP,
  parameter int   COLOR_W    = 1,
  parameter logic SYNC_POL   = 1'b0,
  parameter logic [3*COLOR_W-1:0] FG_COLOR = '1,
  parameter logic [3*COLOR_W-1:0] BG_COLOR = '0,
  parameter int   CHECK_LOG2 = 5,
  parameter int   GRAD_SHIFT = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [1:0]           mode,
  output logic                 h_sync,
  output logic                 v_sync,
  output logic [3*COLOR_W-1:0] RGB,
  output logic                 display_en,
  output logic [clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0] x,
  output logic [clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0] y,
  output logic                 frame_start
);

  localparam int XW    = clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int YW    = clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int BAR_W = (H_ACTIVE / 8 < 1) ? 1 : H_ACTIVE / 8;
  localparam logic [XW-1:0] BAR_LAST = XW'(BAR_W - 1);

  logic [XW-1:0]        h_cnt;
  logic [YW-1:0]        v_cnt;
  logic                 hs_raw;
  logic                 vs_raw;
  logic                 active;
  logic                 at_origin;
  logic                 line_end;
  logic [XW-1:0]        bar_pix;
  logic [2:0]           bar_idx;
  mode_t                mode_q;
  mode_t                mode_eff;
  logic                 check_bit;
  logic [COLOR_W-1:0]   level;
  logic [3*COLOR_W-1:0] pattern;

  vga_sync_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL),
    .XW       (XW),
    .YW       (YW)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .h_sync    (hs_raw),
    .v_sync    (vs_raw),
    .active    (active),
    .at_origin (at_origin),
    .line_end  (line_end)
  );

  // At the frame origin the new mode applies to that very pixel, so the
  // first pixel of a frame and the rest of it always agree.
  assign mode_eff  = at_origin ? mode_t'(mode) : mode_q;
  assign check_bit = h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2];
  assign level     = h_cnt[GRAD_SHIFT +: COLOR_W];

  // Bar index tracks h_cnt by counting BAR_W pixels per bar, saturating at 7.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bar_pix <= '0;
      bar_idx <= '0;
    end else if (!enable || line_end) begin
      bar_pix <= '0;
      bar_idx <= '0;
    end else if (bar_pix == BAR_LAST) begin
      bar_pix <= '0;
      if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_pix <= bar_pix + XW'(1);
    end
  end

  // Pattern colour for the pixel currently addressed by the counters.
  always_comb begin
    pattern = FG_COLOR;
    case (mode_eff)
      MODE_SOLID: pattern = FG_COLOR;
      MODE_BARS:  pattern = {{COLOR_W{bar_idx[2]}}, {COLOR_W{bar_idx[1]}}, {COLOR_W{bar_idx[0]}}};
      MODE_CHECK: pattern = check_bit ? BG_COLOR : FG_COLOR;
      MODE_GRAD:  pattern = {3{level}};
      default:    pattern = FG_COLOR;
    endcase
  end

  // Output stage and frame-aligned mode register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_sync      <= ~SYNC_POL;
      v_sync      <= ~SYNC_POL;
      RGB         <= '0;
      display_en  <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      mode_q      <= MODE_SOLID;
    end else if (!enable) begin
      h_sync      <= ~SYNC_POL;
      v_sync      <= ~SYNC_POL;
      RGB         <= '0;
      display_en  <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else begin
      h_sync      <= hs_raw;
      v_sync      <= vs_raw;
      RGB         <= active ? pattern : '0;
      display_en  <= active;
      x           <= h_cnt;
      y           <= v_cnt;
      frame_start <= at_origin;
      if (at_origin) mode_q <= mode_eff;
    end
  end

endmodule

// File: doc/vga_pattern_controller.md
Name: vga_pattern_controller

Overview:
Parametrised VGA timing generator and test-pattern source, the next generation of the fixed-640x480, single-colour vga_controller. Timing, colour depth and sync polarity are parameters. Four runtime-selectable patterns replace the single compile-time colour. It exposes pixel coordinates and frame markers so downstream pixel sources can align to the raster.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
COLOR_W, 1, bits per colour channel; RGB width = 3*COLOR_W
SYNC_POL, 0, active sync level (0 = active-low)
FG_COLOR, all-ones, foreground colour {R,G,B}
BG_COLOR, 0, background colour
CHECK_LOG2, 5, checkerboard square size = 2^CHECK_LOG2 pixels
GRAD_SHIFT, 0, right shift applied to x for the gradient level

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous active-low reset
enable  in  1  run raster; low = idle
mode  in  2  pattern: 0 solid FG, 1 colour bars, 2 checkerboard, 3 grey gradient
h_sync  out  1  horizontal sync
v_sync  out  1  vertical sync
RGB  out  3*COLOR_W  pixel colour {R,G,B}
display_en  out  1  high during active region
x  out  clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)  current h count
y  out  clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)  current v count
frame_start  out  1  one-clock pulse at x=0,y=0

Behaviour:
- Reset (reset=0, asynchronous): h/v counters=0, h_sync=v_sync=~SYNC_POL, RGB=0, display_en=0, x=y=0, frame_start=0, mode register=0.
- H_TOTAL = sum of H params; V_TOTAL = sum of V params. h_cnt runs 0..H_TOTAL-1 and wraps. v_cnt increments on h wrap and wraps at V_TOTAL-1.
- Active region: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- h_sync is at SYNC_POL for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; v_sync is defined the same way on v_cnt.
- All outputs are registered with one clock of latency from the counters. x, y, h_sync, v_sync, display_en, RGB and frame_start are mutually aligned.
- RGB=0 whenever display_en=0.
- mode is sampled into an internal register only when h_cnt=0 and v_cnt=0. A mid-frame change takes effect at the next frame_start.
- Solid: RGB=FG_COLOR.
- Colour bars: BAR_W=H_ACTIVE/8 (elaboration-time integer division). Bar index i=min(x/BAR_W,7), tracked with a bar counter, not a divider. Each channel is all-ones if its bit of i is set, else 0, with R=i[2], G=i[1], B=i[0].
- Checkerboard: RGB = ((x>>CHECK_LOG2)^(y>>CHECK_LOG2))[0] ? BG_COLOR : FG_COLOR.
- Gradient: level=(x>>GRAD_SHIFT) truncated to COLOR_W bits, replicated into R, G and B.
- enable=0: counters clear to 0 and hold. Outputs go to their reset values on the next edge.
- enable 0->1: counting begins from 0,0. frame_start is asserted one clock later.
- Reset mid-frame: immediate return to reset values. After release, behaviour is identical to power-up.

Decomposition:
- vga_pkg: mode encodings (MODE_SOLID, MODE_BARS, MODE_CHECK, MODE_GRAD), 640x480@60 default timing constants, clog2 helper.
- Sub-module vga_sync_counter: h/v counters, wrap logic, sync/active decode, enable handling.
- The top instantiates vga_sync_counter and adds the mode register, pattern generator and output registers.

Test Plan:
Use the small configuration H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL=24), V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8), COLOR_W=1, CHECK_LOG2=1, and a 40 ns clock.
1. Sync timing, mode 0, enable=1: h_sync low exactly when x=18..20 (period 24 clk); v_sync low for y=5..6 (48 clk, period 192 clk); display_en high for x<16, y<4; RGB=3'b111 when active and 0 otherwise.
2. Colour bars, mode=1 from reset: on line y=0, RGB steps 000, 001, ..., 111, two pixels each; RGB=0 for x=16..23.
3. Checkerboard, mode=2: RGB=111 at (0,0) and (1,1); 000 at (2,0) and (0,2); 111 at (2,2).
4. Mode change: switch mode 0->1 when y=2 -> RGB stays solid until the next frame_start, then shows bars from x=0, y=0.
5. Async reset: pull reset low at x=7, y=1 -> all outputs at reset values before the next edge. After release, frame_start pulses and x/y count from 0.
6. Enable toggle: enable=0 for 10 clk mid-line -> h_sync=v_sync=1, RGB=0, x=y=0 held. After re-enable, frame_start is seen one clock later and timing repeats scenario 1.
